// File: rtl/mcp_loader.sv
// mcp_loader: byte-stream writer for the microstore; packs 3 bytes per word,
// writes consecutive addresses, checks a trailing mod-256 checksum.
module mcp_loader #(
    parameter int AW = 11,
    parameter int DW = 22
) (
    input  logic          pin_clk,
    input  logic          pin_rst,
    input  logic          pin_start,
    input  logic [AW-1:0] pin_base,
    input  logic [AW:0]   pin_count,
    input  logic [7:0]    pin_sdat,
    input  logic          pin_sval,
    output logic          pin_srdy,
    output logic [AW-1:0] pin_wa,
    output logic [DW-1:0] pin_wd,
    output logic          pin_we,
    output logic          pin_busy,
    output logic          pin_done,
    output logic          pin_err,
    output logic [AW:0]   pin_nwr
);
    typedef enum logic [2:0] {IDLE, B0, B1, B2, WR, CSUM, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, wa_q, wa_d;
    logic [AW:0]   rem_q, rem_d, nwr_q, nwr_d;
    logic [15:0]   lo_q, lo_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [7:0]    sum_q, sum_d;
    logic          err_q, err_d;
    logic          take, fmt_bad;

    always_comb begin
        pin_srdy = state_q inside {B0, B1, B2, CSUM};
        pin_we   = state_q == WR;
        pin_busy = state_q != IDLE;
        pin_done = state_q == FIN;
        pin_err  = err_q;
        pin_nwr  = nwr_q;
        pin_wa   = wa_q;
        pin_wd   = wd_q;
        take     = pin_sval && pin_srdy;
        // top byte may only carry DW-16 bits; anything above is a format error
        fmt_bad  = (pin_sdat >> (DW - 16)) != 8'd0;
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        nwr_d    = nwr_q;
        lo_d     = lo_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        err_d    = err_q;
        sum_d    = take ? sum_q + pin_sdat : sum_q;
        case (state_q)
            IDLE: if (pin_start) begin
                addr_d  = pin_base;
                rem_d   = pin_count;
                nwr_d   = '0;
                sum_d   = '0;
                err_d   = pin_count > {1'b1, {AW{1'b0}}};
                state_d = err_d ? FIN : (pin_count == '0) ? CSUM : B0;
            end
            B0: if (take) begin
                lo_d[7:0] = pin_sdat;
                state_d   = B1;
            end
            B1: if (take) begin
                lo_d[15:8] = pin_sdat;
                state_d    = B2;
            end
            B2: if (take) begin
                if (fmt_bad) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wa_d    = addr_q;
                    wd_d    = {pin_sdat[DW-17:0], lo_q};
                    state_d = WR;
                end
            end
            WR: begin
                addr_d  = addr_q + 1'b1;
                nwr_d   = nwr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == (AW+1)'(1)) ? CSUM : B0;
            end
            CSUM: if (take) begin
                err_d   = err_q | (sum_d != 8'd0);
                state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            nwr_q   <= '0;
            lo_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            nwr_q   <= nwr_d;
            lo_q    <= lo_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mcp_loader.sv
// tb_mcp_loader: directed and random loads checked against a list-level
// model of the byte stream (words, writes, checksum, bytes consumed).
module tb_mcp_loader;
    localparam int AW = 11;
    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          pin_start;
    logic [AW-1:0] pin_base;
    logic [AW:0]   pin_count;
    logic [7:0]    pin_sdat;
    logic          pin_sval;
    logic          pin_srdy;
    logic [AW-1:0] pin_wa;
    logic [DW-1:0] pin_wd;
    logic          pin_we;
    logic          pin_busy;
    logic          pin_done;
    logic          pin_err;
    logic [AW:0]   pin_nwr;

    mcp_loader #(.AW(AW), .DW(DW)) dut (
        .pin_clk(clk), .pin_rst(rst), .pin_start(pin_start), .pin_base(pin_base),
        .pin_count(pin_count), .pin_sdat(pin_sdat), .pin_sval(pin_sval),
        .pin_srdy(pin_srdy), .pin_wa(pin_wa), .pin_wd(pin_wd), .pin_we(pin_we),
        .pin_busy(pin_busy), .pin_done(pin_done), .pin_err(pin_err), .pin_nwr(pin_nwr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] bytes_q[$];
    int exp_wa[$], exp_wd[$], obs_wa[$], obs_wd[$];
    int exp_err, exp_nwr, exp_used;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_srdy"}, longint'(pin_srdy), 0);
        check({tag, "_we"}, longint'(pin_we), 0);
        check({tag, "_busy"}, longint'(pin_busy), 0);
        check({tag, "_done"}, longint'(pin_done), 0);
        check({tag, "_err"}, longint'(pin_err), 0);
        check({tag, "_wa"}, longint'(pin_wa), 0);
        check({tag, "_wd"}, longint'(pin_wd), 0);
        check({tag, "_nwr"}, longint'(pin_nwr), 0);
    endtask

    // words are read straight off the byte list; the trailer follows the last word
    task automatic model(input int base, input int count);
        int sum, b0, b1, b2;
        exp_wa.delete();
        exp_wd.delete();
        sum = 0;
        exp_err = 0;
        if (count > (1 << AW)) begin
            exp_err = 1; exp_nwr = 0; exp_used = 0;
            return;
        end
        for (int i = 0; i < count; i++) begin
            b0 = int'(bytes_q[3*i]);
            b1 = int'(bytes_q[3*i+1]);
            b2 = int'(bytes_q[3*i+2]);
            sum += b0 + b1 + b2;
            if (b2 >= (1 << (DW - 16))) begin
                exp_err = 1; exp_nwr = i; exp_used = 3*i + 3;
                return;
            end
            exp_wa.push_back((base + i) % (1 << AW));
            exp_wd.push_back(b0 + 256*b1 + 65536*b2);
        end
        exp_nwr = count;
        exp_used = 3*count + 1;
        if ((sum + int'(bytes_q[3*count])) % 256 != 0) exp_err = 1;
    endtask

    task automatic run_load(input string tag, input int base, input int count,
                            input int gap, input bit start_mid, input int abort_at);
        int used;
        bit got_done;
        model(base, count);
        obs_wa.delete();
        obs_wd.delete();
        used = 0;
        got_done = 0;
        @(negedge clk);
        pin_start = 1'b1;
        pin_base  = AW'(base);
        pin_count = (AW+1)'(count);
        @(negedge clk);
        pin_start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (pin_we) begin
                obs_wa.push_back(int'(pin_wa));
                obs_wd.push_back(int'(pin_wd));
            end
            if (pin_done) begin
                got_done = 1;
                break;
            end
            pin_start = start_mid && cyc == 4;
            if (pin_start) begin
                pin_base  = AW'($urandom);
                pin_count = (AW+1)'(5);
            end
            pin_sval = (used < bytes_q.size()) && ($urandom_range(99) >= gap);
            pin_sdat = pin_sval ? bytes_q[used] : 8'($urandom);
            if (pin_sval && pin_srdy) used++;
            if (abort_at >= 0 && used == abort_at) begin
                @(posedge clk);
                #2;
                pin_sval = 1'b0;
                return;
            end
            @(negedge clk);
        end
        pin_sval  = 1'b0;
        pin_start = 1'b0;
        check({tag, "_done"}, longint'(got_done), 1);
        check({tag, "_err"}, longint'(pin_err), exp_err);
        check({tag, "_nwr"}, longint'(pin_nwr), exp_nwr);
        check({tag, "_used"}, used, exp_used);
        check({tag, "_srdy_fin"}, longint'(pin_srdy), 0);
        check({tag, "_nwrites"}, obs_wa.size(), exp_wa.size());
        for (int i = 0; i < obs_wa.size() && i < exp_wa.size(); i++) begin
            check({tag, "_wa"}, obs_wa[i], exp_wa[i]);
            check({tag, "_wd"}, obs_wd[i], exp_wd[i]);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, longint'(pin_done), 0);
        check({tag, "_busy_after"}, longint'(pin_busy), 0);
    endtask

    initial begin
        int nwe, sum, cnt;
        rst = 1'b1;
        pin_start = 1'b0;
        pin_sval = 1'b0;
        pin_sdat = '0;
        pin_base = '0;
        pin_count = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        bytes_q = '{8'hFF, 8'hFF, 8'h3F, 8'hC3, 8'h11, 8'h22};
        run_load("one", 'h7FF, 1, 0, 0, -1);
        bytes_q = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hFA, 8'h55};
        run_load("three", 'h7FE, 3, 0, 0, -1);
        bytes_q = '{8'hFF, 8'hFF, 8'h3F, 8'hC4, 8'h11};
        run_load("badsum", 'h7FF, 1, 0, 0, -1);
        bytes_q = '{8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load("fmt", 'h010, 2, 0, 0, -1);
        bytes_q = '{8'hFF, 8'hFF, 8'h3F, 8'hC3, 8'h11, 8'h22};
        run_load("bp", 'h7FF, 1, 60, 0, -1);
        bytes_q = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hFA, 8'h55};
        run_load("midstart", 'h7FE, 3, 30, 1, -1);
        bytes_q = '{8'h00, 8'h77};
        run_load("zero", 'h123, 0, 0, 0, -1);
        bytes_q = '{8'h00, 8'h01};
        run_load("over", 'h005, 'h801, 0, 0, -1);

        bytes_q = '{8'h12, 8'h34, 8'h16, 8'hAB, 8'hCD, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load("abort", 'h100, 3, 0, 0, 5);
        rst = 1'b1;
        #1;
        check_idle("midrst");
        nwe = 0;
        repeat (4) begin
            @(negedge clk);
            nwe += int'(pin_we);
        end
        check("midrst_nowe", nwe, 0);
        rst = 1'b0;
        bytes_q = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hFA};
        run_load("fresh", 'h7FE, 3, 20, 0, -1);

        for (int r = 0; r < 12; r++) begin
            bytes_q.delete();
            cnt = $urandom_range(5, 1);
            sum = 0;
            for (int i = 0; i < 3*cnt; i++) begin
                bytes_q.push_back((i % 3 == 2 && $urandom_range(7) != 0) ? 8'($urandom) & 8'h3F
                                                                          : 8'($urandom));
                sum += int'(bytes_q[i]);
            end
            bytes_q.push_back($urandom_range(3) != 0 ? 8'((256 - sum % 256) % 256) : 8'($urandom));
            repeat (3) bytes_q.push_back(8'($urandom));
            run_load("rand", $urandom_range(2047), cnt, $urandom_range(70), 1'($urandom_range(1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mcp_loader.md
Name: mcp_loader

Overview:
- Writer side of the 2048x22 MicROM microinstruction store; the read side is addressed by the location counter.
- Accepts a byte stream (valid/ready) from the host or debug link.
- Assembles each 3-byte group into one 22-bit microinstruction and writes it into the RAM-based microstore at consecutive addresses.
- Verifies a trailing 8-bit checksum, and holds the CPU sequencer stalled via pin_busy while loading.

Parameters:
- AW, 11, microstore address width (store depth 2^AW; 2048 by default).
- DW, 22, microinstruction width; must be 17..24 so that exactly 3 bytes carry one word.

Ports:
- pin_clk  in  1  main clock
- pin_rst  in  1  reset, asynchronous, active-high
- pin_start  in  1  single-cycle load request, sampled only in IDLE
- pin_base  in  AW  first store address, latched on accepted start
- pin_count  in  AW+1  number of words to load, 0..2^AW, latched on accepted start
- pin_sdat  in  8  stream byte
- pin_sval  in  1  stream byte valid
- pin_srdy  out  1  loader ready; a byte transfers when pin_sval and pin_srdy are both 1 on a clock edge
- pin_wa  out  AW  store write address
- pin_wd  out  DW  store write data
- pin_we  out  1  store write strobe, one cycle per word
- pin_busy  out  1  load in progress; stalls the sequencer
- pin_done  out  1  one-cycle completion pulse
- pin_err  out  1  sticky error; cleared on the next accepted start
- pin_nwr  out  AW+1  words written in the current or last load

Behaviour:
- Reset (asynchronous, pin_rst=1):
  - State returns to IDLE immediately.
  - All outputs are 0: pin_srdy, pin_we, pin_busy, pin_done, pin_err, pin_wa, pin_wd, pin_nwr.
  - A reset mid-load discards any partial word, and the checksum accumulator is cleared.
- States are IDLE, B0, B1, B2, WR, CSUM, FIN.
- IDLE:
  - pin_srdy=0 and pin_busy=0.
  - pin_start=1 latches base and count, clears pin_err, pin_nwr and the checksum, sets pin_busy on the next cycle, and moves to B0.
  - If pin_count > 2^AW, set pin_err and move to FIN instead.
  - If pin_count = 0, move to CSUM.
- Start outside IDLE is ignored.
- B0, B1, B2:
  - pin_srdy=1.
  - Each accepted byte is added mod 256 to the checksum and the state advances.
  - Byte order is little endian: B0 gives wd[7:0], B1 gives wd[15:8], B2 gives wd[DW-1:16].
  - If B2 has any bit at or above DW-16 set, this is a format error: set pin_err, do not write, go to FIN.
  - When pin_sval=0 the state holds indefinitely; there is no timeout.
- WR (one cycle):
  - pin_srdy=0 and pin_we=1; pin_wa and pin_wd are stable for that cycle.
  - Next cycle: the address increments mod 2^AW (wraps 2047 to 0), pin_nwr increments, and the remaining count decrements.
  - If the remaining count reaches 0, go to CSUM; otherwise go to B0.
- Throughput is at most one word per 4 clocks.
- CSUM:
  - pin_srdy=1 and exactly one trailer byte is accepted.
  - The mod-256 sum of all payload bytes plus the trailer must equal 0x00; otherwise set pin_err.
  - Go to FIN.
- FIN (one cycle):
  - pin_done=1 and pin_srdy=0; pin_busy remains 1 this cycle.
  - Next cycle: IDLE, with pin_busy=0.
  - pin_err and pin_nwr hold until the next start.
- Words already written before an error are not rolled back.
- pin_wa and pin_wd hold their last values outside WR.

Test Plan:
- Load 1 word: base=0x7FF, count=1, bytes FF FF 3F, trailer C3 -> one pin_we at wa=0x7FF with wd=0x3FFFFF; pin_done with pin_err=0 and pin_nwr=1.
- Load 3 words: base=0x7FE, bytes 01 00 00 / 02 00 00 / 03 00 00, trailer FA -> writes 0x7FE=0x000001, 0x7FF=0x000002, then wraps to 0x000=0x000003; pin_err=0.
- Bad checksum: same as the first scenario but trailer C4 -> the word is still written; pin_done=1, pin_err=1.
- Format error: count=2, first word bytes 00 00 40 -> no pin_we; pin_done follows the 3rd byte, pin_err=1, pin_nwr=0; the remaining stream is not consumed (pin_srdy=0).
- Backpressure and protocol:
  - pin_sval toggled randomly -> the loaded result is identical to the first scenario.
  - pin_start pulsed mid-load -> ignored.
  - count=0 with trailer 00 -> done, no writes, pin_err=0.
  - count=0x801 -> immediate done with pin_err=1.
- Reset mid-load: pin_rst asserted after the B1 byte of word 2 -> all outputs 0 at once with no further pin_we; a fresh load then succeeds with the correct checksum.
